// File: rtl/inst_decode_if.sv
// ID-stage bus: IF/ID and WB inputs, hazard/flush controls, ID/EX outputs
// and the combinational source indices returned to the hazard unit.
interface inst_decode_if;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic [3:0]  status;
  logic        wbEn;
  logic [3:0]  wbDest;
  logic [31:0] wbValue;
  logic        hazard;
  logic        flush;
  logic        wbEnOut;
  logic        memReadOut;
  logic        memWriteOut;
  logic [3:0]  exeCmdOut;
  logic        sOut;
  logic        bOut;
  logic [31:0] pc4Out;
  logic [31:0] val1Out;
  logic [31:0] valRmOut;
  logic        immOut;
  logic [11:0] shiftOperandOut;
  logic [23:0] imm24Out;
  logic [3:0]  destOut;
  logic [3:0]  hzSrc1;
  logic [3:0]  hzSrc2;
  logic        twoSrc;

  modport master (
    output instruction, pc4, status, wbEn, wbDest, wbValue, hazard, flush,
    input  wbEnOut, memReadOut, memWriteOut, exeCmdOut, sOut, bOut, pc4Out,
           val1Out, valRmOut, immOut, shiftOperandOut, imm24Out, destOut,
           hzSrc1, hzSrc2, twoSrc
  );
  modport slave (
    input  instruction, pc4, status, wbEn, wbDest, wbValue, hazard, flush,
    output wbEnOut, memReadOut, memWriteOut, exeCmdOut, sOut, bOut, pc4Out,
           val1Out, valRmOut, immOut, shiftOperandOut, imm24Out, destOut,
           hzSrc1, hzSrc2, twoSrc
  );
endinterface

// File: rtl/inst_decode.sv
// ARM-subset instruction decode stage: control decode, condition check,
// 15-entry register file with WB bypass, and the ID/EX pipeline register.
module inst_decode (
  input logic       clk,
  input logic       rst,
  inst_decode_if.slave bus
);
  typedef struct packed {
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  exe;
    logic        s;
    logic        b;
    logic [31:0] pc4;
    logic [31:0] v1;
    logic [31:0] vrm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] i24;
    logic [3:0]  dst;
  } idex_t;

  logic [31:0] r_rf [0:14];
  idex_t       r_idex;

  logic [3:0]  w_cond, w_op, w_rn, w_rd, w_rm, w_src2, w_exe;
  logic [1:0]  w_mode;
  logic        w_i, w_s, w_n, w_z, w_c, w_v, w_pass, w_str;
  logic        w_wb, w_mr, w_mw, w_sf, w_b;
  logic [31:0] w_v1, w_vrm;
  idex_t       w_dec;

  assign w_cond = bus.instruction[31:28];
  assign w_mode = bus.instruction[27:26];
  assign w_i    = bus.instruction[25];
  assign w_op   = bus.instruction[24:21];
  assign w_s    = bus.instruction[20];
  assign w_rn   = bus.instruction[19:16];
  assign w_rd   = bus.instruction[15:12];
  assign w_rm   = bus.instruction[3:0];
  assign {w_n, w_z, w_c, w_v} = bus.status;

  // STR reads Rd as its store data, so it becomes the second hazard source
  assign w_str      = (w_mode == 2'b01) && !w_s;
  assign w_src2     = w_str ? w_rd : w_rm;
  assign bus.hzSrc1 = w_rn;
  assign bus.hzSrc2 = w_src2;
  assign bus.twoSrc = ((w_mode == 2'b00) && !w_i) || w_str;

  // condition-code evaluation against {N,Z,C,V}
  always_comb begin
    w_pass = 1'b0;
    case (w_cond)
      4'h0: w_pass = w_z;
      4'h1: w_pass = !w_z;
      4'h2: w_pass = w_c;
      4'h3: w_pass = !w_c;
      4'h4: w_pass = w_n;
      4'h5: w_pass = !w_n;
      4'h6: w_pass = w_v;
      4'h7: w_pass = !w_v;
      4'h8: w_pass = w_c && !w_z;
      4'h9: w_pass = !w_c || w_z;
      4'hA: w_pass = (w_n == w_v);
      4'hB: w_pass = (w_n != w_v);
      4'hC: w_pass = !w_z && (w_n == w_v);
      4'hD: w_pass = w_z || (w_n != w_v);
      4'hE: w_pass = 1'b1;
      default: w_pass = 1'b0;
    endcase
  end

  // control decode; exeCmd survives a failed condition, side effects do not
  always_comb begin
    w_exe = 4'd0; w_wb = 1'b0; w_mr = 1'b0; w_mw = 1'b0; w_sf = 1'b0; w_b = 1'b0;
    case (w_mode)
      2'b00: begin
        w_wb = 1'b1;
        w_sf = w_s;
        case (w_op)
          4'b1101: w_exe = 4'b0001;
          4'b1111: w_exe = 4'b1001;
          4'b0100: w_exe = 4'b0010;
          4'b0101: w_exe = 4'b0011;
          4'b0010: w_exe = 4'b0100;
          4'b0110: w_exe = 4'b0101;
          4'b0000: w_exe = 4'b0110;
          4'b1100: w_exe = 4'b0111;
          4'b0001: w_exe = 4'b1000;
          4'b1010: begin w_exe = 4'b0100; w_wb = 1'b0; end
          4'b1000: begin w_exe = 4'b0110; w_wb = 1'b0; end
          default: begin w_wb = 1'b0; w_sf = 1'b0; end
        endcase
      end
      2'b01: begin
        w_exe = 4'b0010;
        w_mr  = w_s;
        w_wb  = w_s;
        w_mw  = !w_s;
      end
      2'b10: w_b = 1'b1;
      default: ;
    endcase
  end

  // register reads: PC alias at 15, then same-cycle writeback bypass
  always_comb begin
    if (w_rn == 4'd15)                           w_v1 = bus.pc4;
    else if (bus.wbEn && bus.wbDest == w_rn)     w_v1 = bus.wbValue;
    else                                         w_v1 = r_rf[w_rn];
    if (w_src2 == 4'd15)                         w_vrm = bus.pc4;
    else if (bus.wbEn && bus.wbDest == w_src2)   w_vrm = bus.wbValue;
    else                                         w_vrm = r_rf[w_src2];
  end

  // assemble the next ID/EX contents
  always_comb begin
    w_dec     = '0;
    w_dec.wb  = w_wb && w_pass;
    w_dec.mr  = w_mr && w_pass;
    w_dec.mw  = w_mw && w_pass;
    w_dec.exe = w_exe;
    w_dec.s   = w_sf && w_pass;
    w_dec.b   = w_b && w_pass;
    w_dec.pc4 = bus.pc4;
    w_dec.v1  = w_v1;
    w_dec.vrm = w_vrm;
    w_dec.imm = w_i;
    w_dec.sh  = bus.instruction[11:0];
    w_dec.i24 = bus.instruction[23:0];
    w_dec.dst = w_rd;
    if (bus.hazard) begin
      w_dec.wb = 1'b0; w_dec.mr = 1'b0; w_dec.mw = 1'b0;
      w_dec.exe = 4'd0; w_dec.s = 1'b0; w_dec.b = 1'b0;
    end
    if (bus.flush) w_dec = '0;
  end

  // register file: reset to Ri = i; R15 is the PC and is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 15; i++) r_rf[i] <= 32'(i);
    end else if (bus.wbEn && bus.wbDest != 4'd15) begin
      r_rf[bus.wbDest] <= bus.wbValue;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_idex <= '0;
    else      r_idex <= w_dec;
  end

  assign bus.wbEnOut         = r_idex.wb;
  assign bus.memReadOut      = r_idex.mr;
  assign bus.memWriteOut     = r_idex.mw;
  assign bus.exeCmdOut       = r_idex.exe;
  assign bus.sOut            = r_idex.s;
  assign bus.bOut            = r_idex.b;
  assign bus.pc4Out          = r_idex.pc4;
  assign bus.val1Out         = r_idex.v1;
  assign bus.valRmOut        = r_idex.vrm;
  assign bus.immOut          = r_idex.imm;
  assign bus.shiftOperandOut = r_idex.sh;
  assign bus.imm24Out        = r_idex.i24;
  assign bus.destOut         = r_idex.dst;
endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: instruction-level reference model plus directed
// vectors with hand-computed expectations.
module tb_inst_decode;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  inst_decode_if bus ();
  inst_decode dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        wb, mr, mw, s, b, imm;
    logic [3:0]  exe, dst;
    logic [31:0] pc4, v1, vrm;
    logic [11:0] sh;
    logic [23:0] i24;
  } exp_t;

  exp_t        ex;
  logic [31:0] mrf [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // ARM condition: evaluate the base predicate, odd codes invert it
  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] st);
    bit n, z, cy, v, r;
    {n, z, cy, v} = st;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cy;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cy & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? ~r : r;
  endfunction

  function automatic logic [31:0] mread(input logic [3:0] idx);
    if (idx == 15) return bus.pc4;
    if (bus.wbEn && bus.wbDest == idx) return bus.wbValue;
    return mrf[idx];
  endfunction

  task automatic mreset();
    ex = '{default: '0};
    for (int i = 0; i < 15; i++) mrf[i] = i;
  endtask

  // one instruction through the reference model
  task automatic mstep();
    logic [31:0] in;
    logic [3:0]  op, src2;
    bit          ok, is_str, is_ldr, alu, writes;
    exp_t        e;
    in = bus.instruction;
    op = in[24:21];
    e = '{default: '0};
    is_ldr = (in[27:26] == 1) && in[20];
    is_str = (in[27:26] == 1) && !in[20];
    alu = (in[27:26] == 0) && (op inside {4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6,
                                          4'h0, 4'hC, 4'h1, 4'hA, 4'h8});
    writes = alu && !(op inside {4'hA, 4'h8});
    ok = cond_ok(in[31:28], bus.status);
    if (alu) begin
      case (op)
        4'hD: e.exe = 1;  4'hF: e.exe = 9;  4'h4: e.exe = 2;  4'h5: e.exe = 3;
        4'h2: e.exe = 4;  4'h6: e.exe = 5;  4'h0: e.exe = 6;  4'hC: e.exe = 7;
        4'h1: e.exe = 8;  4'hA: e.exe = 4;  default: e.exe = 6;
      endcase
    end
    if (is_ldr || is_str) e.exe = 2;
    e.wb = ok && (writes || is_ldr);
    e.mr = ok && is_ldr;
    e.mw = ok && is_str;
    e.s  = ok && alu && in[20];
    e.b  = ok && (in[27:26] == 2);
    if (bus.hazard) begin
      e.wb = 0; e.mr = 0; e.mw = 0; e.s = 0; e.b = 0; e.exe = 0;
    end
    src2  = is_str ? in[15:12] : in[3:0];
    e.pc4 = bus.pc4;
    e.v1  = mread(in[19:16]);
    e.vrm = mread(src2);
    e.imm = in[25];
    e.sh  = in[11:0];
    e.i24 = in[23:0];
    e.dst = in[15:12];
    if (bus.flush) e = '{default: '0};
    ex = e;
    if (bus.wbEn && bus.wbDest != 15) mrf[bus.wbDest] = bus.wbValue;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) mreset();
    else      mstep();
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] in;
      bit str;
      in  = bus.instruction;
      str = (in[27:26] == 1) && !in[20];
      chk("wbEnOut", 32'(bus.wbEnOut), 32'(ex.wb));
      chk("memReadOut", 32'(bus.memReadOut), 32'(ex.mr));
      chk("memWriteOut", 32'(bus.memWriteOut), 32'(ex.mw));
      chk("exeCmdOut", 32'(bus.exeCmdOut), 32'(ex.exe));
      chk("sOut", 32'(bus.sOut), 32'(ex.s));
      chk("bOut", 32'(bus.bOut), 32'(ex.b));
      chk("pc4Out", bus.pc4Out, ex.pc4);
      chk("val1Out", bus.val1Out, ex.v1);
      chk("valRmOut", bus.valRmOut, ex.vrm);
      chk("immOut", 32'(bus.immOut), 32'(ex.imm));
      chk("shiftOperandOut", 32'(bus.shiftOperandOut), 32'(ex.sh));
      chk("imm24Out", 32'(bus.imm24Out), 32'(ex.i24));
      chk("destOut", 32'(bus.destOut), 32'(ex.dst));
      chk("hzSrc1", 32'(bus.hzSrc1), 32'(in[19:16]));
      chk("hzSrc2", 32'(bus.hzSrc2), 32'(str ? in[15:12] : in[3:0]));
      chk("twoSrc", 32'(bus.twoSrc), 32'((in[27:26] == 0 && !in[25]) || str));
    end
  end

  logic [31:0] pc = 32'h100;

  task automatic drv(input logic [31:0] in, input logic [3:0] st, input bit we,
                     input logic [3:0] wd, input logic [31:0] wv,
                     input bit hz, input bit fl);
    bus.instruction = in; bus.status = st; bus.wbEn = we; bus.wbDest = wd;
    bus.wbValue = wv; bus.hazard = hz; bus.flush = fl;
    pc = pc + 4; bus.pc4 = pc;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    mreset();
    drv(32'hE3A01005, 4'h0, 1, 4'd1, 32'h77, 0, 0);
    #1 chk_en = 1'b1;
    tick(); tick();
    chk("rst_wbEnOut", 32'(bus.wbEnOut), 0);
    chk("rst_pc4Out", bus.pc4Out, 0);
    chk("rst_destOut", 32'(bus.destOut), 0);
    rst = 1'b1;

    // MOV R1,#5
    drv(32'hE3A01005, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("mov_wbEn", 32'(bus.wbEnOut), 1);
    chk("mov_exe", 32'(bus.exeCmdOut), 4'b0001);
    chk("mov_imm", 32'(bus.immOut), 1);
    chk("mov_dest", 32'(bus.destOut), 1);
    chk("mov_shop", 32'(bus.shiftOperandOut), 32'h005);

    // ADDEQ with Z clear: condition fails
    drv(32'h00810002, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("addeq_wbEn", 32'(bus.wbEnOut), 0);
    chk("addeq_exe", 32'(bus.exeCmdOut), 4'b0010);
    chk("addeq_val1", bus.val1Out, 1);
    chk("addeq_valRm", bus.valRmOut, 2);

    // writeback bypass, then the written value from the file
    drv(32'hE0810002, 4'h0, 1, 4'd2, 32'hDEAD, 0, 0); tick();
    chk("bypass_valRm", bus.valRmOut, 32'hDEAD);
    drv(32'hE0810002, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("rf_valRm", bus.valRmOut, 32'hDEAD);

    // STR R3,[R4]
    drv(32'hE5843000, 4'h0, 0, 0, 0, 0, 0); #1;
    chk("str_hzSrc2", 32'(bus.hzSrc2), 3);
    chk("str_twoSrc", 32'(bus.twoSrc), 1);
    tick();
    chk("str_memWrite", 32'(bus.memWriteOut), 1);
    drv(32'hE5843000, 4'h0, 0, 0, 0, 1, 0); tick();
    chk("strhz_memWrite", 32'(bus.memWriteOut), 0);
    chk("strhz_dest", 32'(bus.destOut), 3);
    chk("strhz_val1", bus.val1Out, 4);

    // flush beats hazard; write to R15 ignored
    drv(32'hEA000010, 4'h0, 1, 4'd15, 32'h1234, 1, 1); tick();
    chk("flush_bOut", 32'(bus.bOut), 0);
    chk("flush_imm24", 32'(bus.imm24Out), 0);
    chk("flush_pc4", bus.pc4Out, 0);
    drv(32'hEA000010, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("b_bOut", 32'(bus.bOut), 1);

    // assorted: R15 read, LDR, CMP with S, undefined opcode, mode 11
    drv(32'hE08F0003, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("pc_val1", bus.val1Out, pc);
    drv(32'hE5921004, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("ldr_memRead", 32'(bus.memReadOut), 1);
    drv(32'hE1530004, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("cmp_sOut", 32'(bus.sOut), 1);
    drv(32'hE0E12003, 4'h0, 0, 0, 0, 0, 0); tick();
    drv(32'hEC000000, 4'h0, 0, 0, 0, 0, 0); tick();
    drv(32'hE2521001, 4'h0, 1, 4'd5, 32'hCAFE, 0, 0); tick();

    // every condition code against a spread of flag patterns
    for (int c = 0; c < 16; c++) begin
      drv({4'(c), 28'h0810002}, 4'(c * 7), 0, 0, 0, 0, 0); tick();
      drv({4'(c), 28'h0810002}, 4'(c * 3 + 1), 0, 0, 0, 0, 0); tick();
    end
    drv(32'hC0810002, 4'b0000, 0, 0, 0, 0, 0); tick();
    chk("gt_pass", 32'(bus.wbEnOut), 1);
    drv(32'hF0810002, 4'b0100, 0, 0, 0, 0, 0); tick();
    chk("nv_fail", 32'(bus.wbEnOut), 0);

    // mid-operation reset drops the instruction and the pending write
    drv(32'hE0830003, 4'h0, 1, 4'd3, 32'h55, 0, 0);
    rst = 1'b0; tick();
    chk("midrst_wbEn", 32'(bus.wbEnOut), 0);
    chk("midrst_val1", bus.val1Out, 0);
    rst = 1'b1;
    drv(32'hE0830003, 4'h0, 0, 0, 0, 0, 0); tick();
    chk("postrst_val1", bus.val1Out, 3);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_decode.md
INST_DECODE -- requirements
Module: inst_decode

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 instruction  in  32  instruction from IF/ID register.
REQ-005 pc4  in  32  PC+4 from IF/ID register.
REQ-006 status  in  4  {N,Z,C,V} from status register.
REQ-007 wbEn  in  1  writeback enable from WB stage.
REQ-008 wbDest  in  4  writeback register index.
REQ-009 wbValue  in  32  writeback data.
REQ-010 hazard  in  1  hazard unit stall request; inserts bubble.
REQ-011 flush  in  1  taken branch from EX; kills instruction in ID.
REQ-012 wbEnOut  out  1  registered writeback enable.
REQ-013 memReadOut  out  1  registered LDR flag.
REQ-014 memWriteOut  out  1  registered STR flag.
REQ-015 exeCmdOut  out  4  registered ALU command.
REQ-016 sOut  out  1  registered status-update flag.
REQ-017 bOut  out  1  registered branch flag.
REQ-018 pc4Out  out  32  registered pc4.
REQ-019 val1Out  out  32  registered Rn value.
REQ-020 valRmOut  out  32  registered second-source value.
REQ-021 immOut  out  1  registered I bit (instruction[25]).
REQ-022 shiftOperandOut  out  12  registered instruction[11:0].
REQ-023 imm24Out  out  24  registered instruction[23:0].
REQ-024 destOut  out  4  registered Rd (instruction[15:12]).
REQ-025 hzSrc1 / hzSrc2 / twoSrc  out  4/4/1  combinational source indices and two-source flag for hazard unit.

Function
REQ-026 Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
REQ-027 Mode 00 opcode->exeCmd: MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110; wbEn=1 except CMP/TST; other opcodes decode all-zero controls.
REQ-028 Mode 01: S=1 -> LDR (memRead=1, wbEn=1, exeCmd 0010); S=0 -> STR (memWrite=1, exeCmd 0010); sOut=0 for both.
REQ-029 Mode 10: B=1, all other controls 0; mode 11: all controls 0.
REQ-030 Condition check on status: EQ..LE per ARM table, 1110 AL=pass, 1111=fail; fail forces wbEn, memRead, memWrite, S, B to 0.
REQ-031 Register file: R0-R14, 32 bits each, written at rising edge when wbEn=1 and wbDest!=15; wbDest=15 ignored.
REQ-032 Read bypass: if wbEn=1 and wbDest equals read index, read returns wbValue same cycle; reading index 15 returns pc4.
REQ-033 hzSrc1=Rn; hzSrc2=Rd when STR, else Rm; twoSrc=1 when (mode 00 and I=0) or STR.
REQ-034 ID/EX register priority per rising edge: flush > hazard > load; flush: all outputs 0; hazard: control outputs (wbEn, memRead, memWrite, exeCmd, S, B) 0, data outputs load normally; else load decoded values.
REQ-035 Latency: one cycle from instruction present to registered outputs.

Reset
REQ-036 rst low asynchronously zeroes all registered outputs and sets Ri = i (i=0..14); outputs hold until first rising edge after rst high.
REQ-037 rst asserted mid-operation discards the in-flight instruction; no register-file write occurs while rst low.

Verification
REQ-038 After reset, instruction 0xE3A01005 (MOV R1,#5) -> next edge wbEnOut=1, exeCmdOut=0001, immOut=1, destOut=1, shiftOperandOut=0x005.
REQ-039 status Z=0, instruction 0x00810002 (ADDEQ R0,R1,R2) -> wbEnOut=0, exeCmdOut=0010, val1Out=1, valRmOut=2.
REQ-040 wbEn=1, wbDest=2, wbValue=0xDEAD with ADD R0,R1,R2 in ID -> valRmOut=0xDEAD; next cycle R2 reads 0xDEAD.
REQ-041 STR R3,[R4] (0xE5843000) -> memWriteOut=1, hzSrc2=3, twoSrc=1; with hazard=1 -> memWriteOut=0, destOut=3.
REQ-042 flush=1 and hazard=1 together on B instruction 0xEA000010 -> all outputs 0 next edge; wbEn=1, wbDest=15 -> no register changes.
